tdp_ram_param: RTL and testbench

- Parametrised single-clock true-dual-port block RAM. Successor to the fixed dual-18Kb mapping model.
- Data width, depth and byte-lane size are generic. Each port has its own write-collision mode.
- Optional output pipeline register.
- Built-in post-reset memory clear sequencer that reports busy status.
- Sits between user logic and the BRAM primitive layer. It is the generic target for inferred RAMs.

---
 rtl/tdp_ram_param.sv | 188 ++++++++++++++++++
 tb/tb_tdp_ram_param.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tdp_ram_param.sv
// Parametrised single-clock true-dual-port RAM with byte lanes, per-port write modes and post-reset clear.
// Optional macro TDP_RAM_PARAM_COLLISION_DETECT_EN adds a registered same-address COLLISION pulse.
module tdp_ram_param #(
  parameter int    DATA_WIDTH     = 18,
  parameter int    ADDR_WIDTH     = 10,
  parameter int    BYTE_WIDTH     = 9,
  parameter string WRITE_MODE_A   = "READ_FIRST",
  parameter string WRITE_MODE_B   = "READ_FIRST",
  parameter int    OUT_REG        = 0,
  parameter int    CLEAR_ON_RESET = 1,
  parameter logic [(2**ADDR_WIDTH)*DATA_WIDTH-1:0] INIT = '0,
  localparam int   DEPTH          = 2**ADDR_WIDTH,
  localparam int   BE_WIDTH       = (DATA_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH
) (
`ifdef TDP_RAM_PARAM_COLLISION_DETECT_EN
  output logic                  COLLISION,
`endif
  input  logic                  CLK,
  input  logic                  RESET,
  output logic                  BUSY,
  input  logic                  WEN_A,
  input  logic                  REN_A,
  input  logic [BE_WIDTH-1:0]   BE_A,
  input  logic [ADDR_WIDTH-1:0] ADDR_A,
  input  logic [DATA_WIDTH-1:0] WDATA_A,
  output logic [DATA_WIDTH-1:0] RDATA_A,
  output logic                  RVALID_A,
  input  logic                  WEN_B,
  input  logic                  REN_B,
  input  logic [BE_WIDTH-1:0]   BE_B,
  input  logic [ADDR_WIDTH-1:0] ADDR_B,
  input  logic [DATA_WIDTH-1:0] WDATA_B,
  output logic [DATA_WIDTH-1:0] RDATA_B,
  output logic                  RVALID_B
);

  localparam int MEM_BITS = DEPTH * DATA_WIDTH;
  localparam int IDX_W    = $clog2(MEM_BITS);
  localparam bit RF_A = (WRITE_MODE_A == "READ_FIRST");
  localparam bit WF_A = (WRITE_MODE_A == "WRITE_FIRST");
  localparam bit NC_A = (WRITE_MODE_A == "NO_CHANGE");
  localparam bit RF_B = (WRITE_MODE_B == "READ_FIRST");
  localparam bit WF_B = (WRITE_MODE_B == "WRITE_FIRST");
  localparam bit NC_B = (WRITE_MODE_B == "NO_CHANGE");

  if (DATA_WIDTH < 1 || DATA_WIDTH > 72) begin : g_bad_data_width
    $error("tdp_ram_param: DATA_WIDTH %0d outside 1..72", DATA_WIDTH);
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 15) begin : g_bad_addr_width
    $error("tdp_ram_param: ADDR_WIDTH %0d outside 1..15", ADDR_WIDTH);
  end
  if (!(RF_A || WF_A || NC_A)) begin : g_bad_mode_a
    $error("tdp_ram_param: WRITE_MODE_A %s not supported", WRITE_MODE_A);
  end
  if (!(RF_B || WF_B || NC_B)) begin : g_bad_mode_b
    $error("tdp_ram_param: WRITE_MODE_B %s not supported", WRITE_MODE_B);
  end

  typedef enum logic [1:0] {ST_RST, ST_CLEAR, ST_READY} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  busy_q;
  logic [MEM_BITS-1:0]   mem_q = INIT;

  logic                  act, same_addr, wr_a, wr_b, rd_a_d, rd_b_d;
  logic [IDX_W-1:0]      idx_a, idx_b, idx_clr;
  logic [DATA_WIDTH-1:0] mask_a, mask_b, old_a, old_b, mrg_a, mrg_b;
  logic [DATA_WIDTH-1:0] rd_word_a_d, rd_word_b_d;
  logic                  rvld_a_p0_q, rvld_b_p0_q;
  logic [DATA_WIDTH-1:0] rdata_a_p0_q, rdata_b_p0_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_RST;
      clr_cnt_q <= '0;
      busy_q    <= (CLEAR_ON_RESET != 0);
    end else begin
      case (state_q)
        ST_RST: begin
          clr_cnt_q <= '0;
          if (CLEAR_ON_RESET != 0) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
          end
        end
        ST_CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_WIDTH'(1);
          if (&clr_cnt_q) begin
            state_q <= ST_READY;
            busy_q  <= 1'b0;
          end
        end
        default: busy_q <= 1'b0;
      endcase
    end
  end

  assign BUSY = busy_q;
  // Without a clear pass the first post-reset edge already accepts requests.
  assign act = !RESET && (state_q == ST_READY || (state_q == ST_RST && CLEAR_ON_RESET == 0));

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_mask
    assign mask_a[i] = BE_A[i / BYTE_WIDTH];
    assign mask_b[i] = BE_B[i / BYTE_WIDTH];
  end

  assign idx_a     = IDX_W'(ADDR_A) * IDX_W'(DATA_WIDTH);
  assign idx_b     = IDX_W'(ADDR_B) * IDX_W'(DATA_WIDTH);
  assign idx_clr   = IDX_W'(clr_cnt_q) * IDX_W'(DATA_WIDTH);
  assign old_a     = mem_q[idx_a +: DATA_WIDTH];
  assign old_b     = mem_q[idx_b +: DATA_WIDTH];
  assign same_addr = (ADDR_A == ADDR_B);
  assign wr_a      = act && WEN_A;
  assign wr_b      = act && WEN_B;

  // Port A's merge starts from B's merged word on a shared address, so A wins overlapping lanes.
  assign mrg_b = (old_b & ~mask_b) | (WDATA_B & mask_b);
  assign mrg_a = (((wr_b && same_addr) ? mrg_b : old_a) & ~mask_a) | (WDATA_A & mask_a);

  assign rd_a_d      = act && REN_A && !(NC_A && WEN_A);
  assign rd_b_d      = act && REN_B && !(NC_B && WEN_B);
  assign rd_word_a_d = (WF_A && WEN_A) ? mrg_a : old_a;
  assign rd_word_b_d = (WF_B && WEN_B) ? ((wr_a && same_addr) ? mrg_a : mrg_b) : old_b;

  always @(posedge CLK) begin
    if (!RESET && state_q == ST_CLEAR) mem_q[idx_clr +: DATA_WIDTH] <= '0;
    if (wr_b) mem_q[idx_b +: DATA_WIDTH] <= mrg_b;
    if (wr_a) mem_q[idx_a +: DATA_WIDTH] <= mrg_a;
  end

  // Stage p0: array read register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rvld_a_p0_q  <= 1'b0;
      rvld_b_p0_q  <= 1'b0;
      rdata_a_p0_q <= '0;
      rdata_b_p0_q <= '0;
    end else begin
      rvld_a_p0_q <= rd_a_d;
      rvld_b_p0_q <= rd_b_d;
      if (rd_a_d) rdata_a_p0_q <= rd_word_a_d;
      if (rd_b_d) rdata_b_p0_q <= rd_word_b_d;
    end
  end

  // Stage p1: optional output register, advances every cycle
  if (OUT_REG != 0) begin : g_oreg
    logic                  rvld_a_p1_q, rvld_b_p1_q;
    logic [DATA_WIDTH-1:0] rdata_a_p1_q, rdata_b_p1_q;
    always_ff @(posedge CLK) begin
      if (RESET) begin
        rvld_a_p1_q  <= 1'b0;
        rvld_b_p1_q  <= 1'b0;
        rdata_a_p1_q <= '0;
        rdata_b_p1_q <= '0;
      end else begin
        rvld_a_p1_q <= rvld_a_p0_q;
        rvld_b_p1_q <= rvld_b_p0_q;
        if (rvld_a_p0_q) rdata_a_p1_q <= rdata_a_p0_q;
        if (rvld_b_p0_q) rdata_b_p1_q <= rdata_b_p0_q;
      end
    end
    assign RVALID_A = rvld_a_p1_q;
    assign RVALID_B = rvld_b_p1_q;
    assign RDATA_A  = rdata_a_p1_q;
    assign RDATA_B  = rdata_b_p1_q;
  end else begin : g_no_oreg
    assign RVALID_A = rvld_a_p0_q;
    assign RVALID_B = rvld_b_p0_q;
    assign RDATA_A  = rdata_a_p0_q;
    assign RDATA_B  = rdata_b_p0_q;
  end

`ifdef TDP_RAM_PARAM_COLLISION_DETECT_EN
  logic coll_q;
  always_ff @(posedge CLK) begin
    if (RESET) coll_q <= 1'b0;
    else       coll_q <= act && same_addr &&
                         ((WEN_A && (WEN_B || REN_B)) || (WEN_B && (WEN_A || REN_A)));
  end
  assign COLLISION = coll_q;
`endif

endmodule

// File: tb/tb_tdp_ram_param.sv
// Bench for tdp_ram_param: three instances (different write modes / OUT_REG) share stimulus
// and are checked every cycle against an array-based reference model.
module tb_tdp_ram_param;
  localparam int DW = 18, AW = 10, BW = 9, DEPTH = 1024, ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, wen_a, ren_a, wen_b, ren_b;
  logic [1:0]    be_a, be_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] wdata_a, wdata_b;
  logic          busy [ND];
  logic          rvld_a [ND], rvld_b [ND];
  logic [DW-1:0] rdata_a [ND], rdata_b [ND];
`ifdef TDP_RAM_PARAM_COLLISION_DETECT_EN
  logic          coll [ND];
`endif

  tdp_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
    .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("NO_CHANGE"), .OUT_REG(0),
    .CLEAR_ON_RESET(1), .INIT('1)) u_d0 (
`ifdef TDP_RAM_PARAM_COLLISION_DETECT_EN
    .COLLISION(coll[0]),
`endif
    .CLK(clk), .RESET(rst), .BUSY(busy[0]),
    .WEN_A(wen_a), .REN_A(ren_a), .BE_A(be_a), .ADDR_A(addr_a), .WDATA_A(wdata_a),
    .RDATA_A(rdata_a[0]), .RVALID_A(rvld_a[0]),
    .WEN_B(wen_b), .REN_B(ren_b), .BE_B(be_b), .ADDR_B(addr_b), .WDATA_B(wdata_b),
    .RDATA_B(rdata_b[0]), .RVALID_B(rvld_b[0]));

  tdp_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
    .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST"), .OUT_REG(1),
    .CLEAR_ON_RESET(1), .INIT('1)) u_d1 (
`ifdef TDP_RAM_PARAM_COLLISION_DETECT_EN
    .COLLISION(coll[1]),
`endif
    .CLK(clk), .RESET(rst), .BUSY(busy[1]),
    .WEN_A(wen_a), .REN_A(ren_a), .BE_A(be_a), .ADDR_A(addr_a), .WDATA_A(wdata_a),
    .RDATA_A(rdata_a[1]), .RVALID_A(rvld_a[1]),
    .WEN_B(wen_b), .REN_B(ren_b), .BE_B(be_b), .ADDR_B(addr_b), .WDATA_B(wdata_b),
    .RDATA_B(rdata_b[1]), .RVALID_B(rvld_b[1]));

  tdp_ram_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYTE_WIDTH(BW),
    .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("WRITE_FIRST"), .OUT_REG(0),
    .CLEAR_ON_RESET(1), .INIT('1)) u_d2 (
`ifdef TDP_RAM_PARAM_COLLISION_DETECT_EN
    .COLLISION(coll[2]),
`endif
    .CLK(clk), .RESET(rst), .BUSY(busy[2]),
    .WEN_A(wen_a), .REN_A(ren_a), .BE_A(be_a), .ADDR_A(addr_a), .WDATA_A(wdata_a),
    .RDATA_A(rdata_a[2]), .RVALID_A(rvld_a[2]),
    .WEN_B(wen_b), .REN_B(ren_b), .BE_B(be_b), .ADDR_B(addr_b), .WDATA_B(wdata_b),
    .RDATA_B(rdata_b[2]), .RVALID_B(rvld_b[2]));

  // Mode codes: 0 = read-first, 1 = write-first, 2 = no-change
  int mode_a [ND] = '{0, 1, 2};
  int mode_b [ND] = '{2, 0, 1};
  int outreg [ND] = '{0, 1, 0};

  logic [DW-1:0] mem [DEPTH];
  bit            in_reset = 1'b1;
  int            clear_left = 0;
  bit            e_busy, e_coll;
  bit            e_vl_a [ND], e_vl_b [ND], s_vl_a [ND], s_vl_b [ND];
  logic [DW-1:0] e_rd_a [ND], e_rd_b [ND], s_rd_a [ND], s_rd_b [ND];
  int            n_tests = 0, n_fail = 0;
  int            nbusy;

  function automatic logic [DW-1:0] merge(logic [DW-1:0] old, logic [DW-1:0] wd, logic [1:0] be);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < DW; i++) if (be[i >= BW]) r[i] = wd[i];
    return r;
  endfunction

  task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    logic [DW-1:0] old_a, old_b, new_a, new_b, rwa, rwb;
    bit act, rva, rvb;
    act   = !rst && !in_reset && clear_left == 0;
    old_a = mem[addr_a];
    old_b = mem[addr_b];
    e_coll = act && addr_a == addr_b &&
             ((wen_a && (wen_b || ren_b)) || (wen_b && (wen_a || ren_a)));
    if (rst) begin
      in_reset = 1'b1; clear_left = 0;
    end else if (in_reset) begin
      in_reset = 1'b0; clear_left = DEPTH;
    end else if (clear_left > 0) begin
      mem[DEPTH - clear_left] = '0; clear_left--;
    end else begin
      if (wen_b) mem[addr_b] = merge(mem[addr_b], wdata_b, be_b);
      if (wen_a) mem[addr_a] = merge(mem[addr_a], wdata_a, be_a);
    end
    new_a  = mem[addr_a];
    new_b  = mem[addr_b];
    e_busy = in_reset || clear_left > 0;
    for (int d = 0; d < ND; d++) begin
      rva = act && ren_a && !(mode_a[d] == 2 && wen_a);
      rvb = act && ren_b && !(mode_b[d] == 2 && wen_b);
      rwa = (mode_a[d] == 1 && wen_a) ? new_a : old_a;
      rwb = (mode_b[d] == 1 && wen_b) ? new_b : old_b;
      if (rst) begin
        e_vl_a[d] = 0; e_vl_b[d] = 0; s_vl_a[d] = 0; s_vl_b[d] = 0;
        e_rd_a[d] = '0; e_rd_b[d] = '0; s_rd_a[d] = '0; s_rd_b[d] = '0;
      end else if (outreg[d] != 0) begin
        e_vl_a[d] = s_vl_a[d]; if (s_vl_a[d]) e_rd_a[d] = s_rd_a[d];
        e_vl_b[d] = s_vl_b[d]; if (s_vl_b[d]) e_rd_b[d] = s_rd_b[d];
        s_vl_a[d] = rva; if (rva) s_rd_a[d] = rwa;
        s_vl_b[d] = rvb; if (rvb) s_rd_b[d] = rwb;
      end else begin
        e_vl_a[d] = rva; if (rva) e_rd_a[d] = rwa;
        e_vl_b[d] = rvb; if (rvb) e_rd_b[d] = rwb;
      end
    end
  endtask

  task automatic check_all();
    for (int d = 0; d < ND; d++) begin
      chk($sformatf("busy[%0d]", d), DW'(busy[d]), DW'(e_busy));
      chk($sformatf("rvalid_a[%0d]", d), DW'(rvld_a[d]), DW'(e_vl_a[d]));
      chk($sformatf("rvalid_b[%0d]", d), DW'(rvld_b[d]), DW'(e_vl_b[d]));
      chk($sformatf("rdata_a[%0d]", d), rdata_a[d], e_rd_a[d]);
      chk($sformatf("rdata_b[%0d]", d), rdata_b[d], e_rd_b[d]);
`ifdef TDP_RAM_PARAM_COLLISION_DETECT_EN
      chk($sformatf("collision[%0d]", d), DW'(coll[d]), DW'(e_coll));
`endif
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle();
    wen_a = 0; ren_a = 0; wen_b = 0; ren_b = 0; be_a = '0; be_b = '0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 1100; k++) begin
      step();
      if (busy[0] !== 1'b1) break;
      n++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '1;
    rst = 1; idle(); addr_a = '0; addr_b = '0; wdata_a = '0; wdata_b = '0;
    repeat (3) step();
    chk("reset_busy", DW'(busy[0]), DW'(1));

    // Clear after reset, with a read request held during BUSY
    rst = 0; ren_a = 1; addr_a = 10'd3;
    count_busy(nbusy);
    chk("clear_busy_cycles", DW'(nbusy), DW'(1024));
    idle(); step();
    ren_a = 1; addr_a = 10'd0; ren_b = 1; addr_b = 10'd511; step();
    chk("clear_rd0_vld", DW'(rvld_a[0]), DW'(1));
    chk("clear_rd0", rdata_a[0], 18'h0);
    ren_b = 0; addr_a = 10'd1023; step();
    chk("clear_rd1023", rdata_a[0], 18'h0);
    idle(); step(); step();

    // Read latency and byte enables
    wen_a = 1; addr_a = 10'd5; wdata_a = 18'h2A5A5; be_a = 2'b11; step();
    wdata_a = 18'h1FFFF; be_a = 2'b01; step();
    idle(); ren_a = 1; addr_a = 10'd5; step();
    chk("be_d0_vld", DW'(rvld_a[0]), DW'(1));
    chk("be_d0_data", rdata_a[0], 18'h2A5FF);
    chk("be_d1_vld_early", DW'(rvld_a[1]), DW'(0));
    idle(); step();
    chk("be_d1_vld", DW'(rvld_a[1]), DW'(1));
    chk("be_d1_data", rdata_a[1], 18'h2A5FF);

    // Same-port read/write modes
    wen_a = 1; addr_a = 10'd7; wdata_a = 18'h00011; be_a = 2'b11; step();
    idle(); step();
    wen_a = 1; ren_a = 1; addr_a = 10'd7; wdata_a = 18'h3FFFF; be_a = 2'b11; step();
    chk("rf_data", rdata_a[0], 18'h00011);
    chk("nc_vld", DW'(rvld_a[2]), DW'(0));
    chk("nc_hold", rdata_a[2], 18'h2A5FF);
    idle(); step();
    chk("wf_data", rdata_a[1], 18'h3FFFF);
    ren_a = 1; addr_a = 10'd7; step();
    chk("mode_mem_d0", rdata_a[0], 18'h3FFFF);
    chk("mode_mem_d2", rdata_a[2], 18'h3FFFF);
    idle(); step();

    // Cross-port write-write on one address
    wen_a = 1; addr_a = 10'd20; wdata_a = 18'h12345; be_a = 2'b10;
    wen_b = 1; addr_b = 10'd20; wdata_b = 18'h0ABCD; be_b = 2'b11; step();
`ifdef TDP_RAM_PARAM_COLLISION_DETECT_EN
    chk("ww_collision", DW'(coll[0]), DW'(1));
`endif
    idle(); ren_a = 1; addr_a = 10'd20; step();
`ifdef TDP_RAM_PARAM_COLLISION_DETECT_EN
    chk("ww_collision_end", DW'(coll[0]), DW'(0));
`endif
    chk("ww_merge", rdata_a[0], 18'h123CD);
    idle(); step();

    // Cross-port read-write on one address
    wen_b = 1; addr_b = 10'd9; wdata_b = 18'h00001; be_b = 2'b11; step();
    idle(); wen_a = 1; addr_a = 10'd9; wdata_a = 18'h00FF0; be_a = 2'b11;
    ren_b = 1; addr_b = 10'd9; step();
    chk("rw_old", rdata_b[0], 18'h00001);
    idle(); ren_b = 1; addr_b = 10'd9; step();
    chk("rw_new", rdata_b[0], 18'h00FF0);
    idle(); step();

    // Random traffic, biased to a few addresses to provoke collisions
    for (int k = 0; k < 3000; k++) begin
      wen_a = 1'($urandom); ren_a = 1'($urandom); be_a = 2'($urandom);
      wen_b = 1'($urandom); ren_b = 1'($urandom); be_b = 2'($urandom);
      addr_a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      addr_b = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7)) : AW'($urandom);
      wdata_a = DW'($urandom); wdata_b = DW'($urandom);
      step();
    end
    idle(); step(); step();

    // Reset mid-clear
    rst = 1; step();
    rst = 0; step();
    repeat (300) step();
    rst = 1; step(); step();
    rst = 0;
    count_busy(nbusy);
    chk("reclear_busy_cycles", DW'(nbusy), DW'(1024));
    for (int i = 0; i < DEPTH / 2; i++) begin
      ren_a = 1; addr_a = AW'(i); ren_b = 1; addr_b = AW'(i + DEPTH / 2);
      step();
    end
    idle(); step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
